// File: rtl/risk_cache_arbiter.sv
// Round-robin arbiter sharing the risk cache CPU port between NREQ requesters.
// Only one transaction is outstanding; it is held stable until the cache answers or the wait times out.
module risk_cache_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDXW    = 14,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_rw,
    input  logic [NREQ*IDXW-1:0] req_index,
    input  logic [NREQ*32-1:0]   req_data,
    output logic [NREQ-1:0]      req_done,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err,
    output logic                 cpu_req_valid,
    output logic                 cpu_req_rw,
    output logic [IDXW-1:0]      cpu_req_index,
    output logic [31:0]          cpu_req_data,
    input  logic                 cpu_res_ready,
    input  logic [31:0]          cpu_res_data,
    output logic                 busy,
    output logic [7:0]           timeout_cnt
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic [GW-1:0] rr_ptr, gnt, win;
    logic          win_vld;
    logic [GW:0]   scan;
    logic [CW-1:0] wait_cnt;
    logic          timed_out;

    // wait_cnt holds the number of BUSY cycles already spent; the abort fires in
    // the (TIMEOUT+1)-th BUSY cycle so the error completion lands TIMEOUT+1 cycles
    // after cpu_req_valid rises, and a ready in that same cycle still wins.
    assign timed_out = (wait_cnt == CW'(TIMEOUT));

    // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        scan    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan = {1'b0, rr_ptr} + (GW+1)'(k);
            if (scan >= (GW+1)'(NREQ)) scan = scan - (GW+1)'(NREQ);
            if (req_valid[scan[GW-1:0]]) begin
                win     = scan[GW-1:0];
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld) state_nxt = BUSY;
            BUSY:    if (cpu_res_ready || timed_out) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    assign cpu_req_valid = (state == BUSY);
    assign busy          = (state != IDLE);
    assign req_done      = (state == DONE) ? (NREQ'(1) << gnt) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr        <= '0;
            gnt           <= '0;
            wait_cnt      <= '0;
            cpu_req_rw    <= 1'b0;
            cpu_req_index <= '0;
            cpu_req_data  <= '0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            timeout_cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (win_vld) begin
                    gnt           <= win;
                    cpu_req_rw    <= req_rw[win];
                    cpu_req_index <= req_index[int'(win)*IDXW +: IDXW];
                    cpu_req_data  <= req_data[int'(win)*32 +: 32];
                end
                BUSY: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    if (cpu_res_ready) begin
                        rsp_data <= cpu_res_data;
                        rsp_err  <= 1'b0;
                    end else if (timed_out) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
                    end
                end
                DONE: begin
                    rr_ptr   <= (gnt == GW'(NREQ - 1)) ? '0 : gnt + GW'(1);
                    wait_cnt <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_risk_cache_arbiter.sv
// Scoreboard bench for risk_cache_arbiter: directed scenarios followed by random
// requester/cache traffic, checked against a transaction-level arbitration model.
module tb_risk_cache_arbiter;
    localparam int NREQ    = 4;
    localparam int IDXW    = 14;
    localparam int TIMEOUT = 64;
    localparam int GW      = $clog2(NREQ);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      rv = '0;
    logic [NREQ-1:0]      rw_v = '0;
    logic [IDXW-1:0]      ridx [NREQ];
    logic [31:0]          rdat [NREQ];
    logic [NREQ*IDXW-1:0] req_index;
    logic [NREQ*32-1:0]   req_data;
    logic [NREQ-1:0]      req_done;
    logic [31:0]          rsp_data;
    logic                 rsp_err;
    logic                 cpu_req_valid, cpu_req_rw;
    logic [IDXW-1:0]      cpu_req_index;
    logic [31:0]          cpu_req_data;
    logic                 cpu_res_ready = 1'b0;
    logic [31:0]          cpu_res_data = '0;
    logic                 busy;
    logic [7:0]           timeout_cnt;

    risk_cache_arbiter #(.NREQ(NREQ), .IDXW(IDXW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(rv), .req_rw(rw_v), .req_index(req_index), .req_data(req_data),
        .req_done(req_done), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .cpu_req_valid(cpu_req_valid), .cpu_req_rw(cpu_req_rw),
        .cpu_req_index(cpu_req_index), .cpu_req_data(cpu_req_data),
        .cpu_res_ready(cpu_res_ready), .cpu_res_data(cpu_res_data),
        .busy(busy), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_index[i*IDXW +: IDXW] = ridx[i];
            req_data[i*32 +: 32]      = rdat[i];
        end
    end

    typedef struct {
        int          w;
        logic [31:0] data;
        logic        err;
        int          cyc;
        int          tcnt;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_tests = 0, n_fail = 0;

    // Reference model state: transaction-level view of the shared port.
    int            ptr = 0;
    bit            act = 0;
    logic [GW-1:0] cur_w = '0;
    int            t0 = 0, lat = 0, exp_done = -1, exp_rise = -1, last_done = -1;
    int            n_done = 0, m_tcnt = 0, mode = 0, force_lat = 0;
    bit            force_d_en = 0;
    logic [31:0]   force_d = '0, rdy_data = '0;
    logic          gr_rw;
    logic [IDXW-1:0] gr_idx;
    logic [31:0]   gr_dat;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endfunction

    function automatic int rr_pick(logic [NREQ-1:0] v, int p);
        for (int k = 0; k < NREQ; k++)
            if (((v >> ((p + k) % NREQ)) & NREQ'(1)) != '0) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic void plan();
        exp_rise = (!rst && !act && cyc > last_done && rv != '0) ? cyc + 1 : -1;
    endfunction

    task automatic new_req(logic [GW-1:0] i);
        rw_v[i] = 1'($urandom_range(0, 1));
        ridx[i] = IDXW'($urandom);
        rdat[i] = $urandom;
        rv[i]   = 1'b1;
    endtask

    task automatic chk_reset();
        chk("rst_cpu_valid", 32'(cpu_req_valid), 0);
        chk("rst_cpu_rw", 32'(cpu_req_rw), 0);
        chk("rst_cpu_index", 32'(cpu_req_index), 0);
        chk("rst_cpu_data", cpu_req_data, 0);
        chk("rst_req_done", 32'(req_done), 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_timeout_cnt", 32'(timeout_cnt), 0);
    endtask

    // One cycle: observe the port at negedge, advance the model, drive requesters and cache.
    task automatic step();
        int   w, r;
        exp_t e;
        @(negedge clk);
        if (exp_rise == cyc) begin
            chk("grant_rise", 32'(cpu_req_valid), 1);
            if (cpu_req_valid) begin
                w = rr_pick(rv, ptr);
                if (w < 0) w = 0;
                cur_w  = GW'(w);
                gr_rw  = rw_v[cur_w];
                gr_idx = ridx[cur_w];
                gr_dat = rdat[cur_w];
                chk("grant_rw", 32'(cpu_req_rw), 32'(gr_rw));
                chk("grant_index", 32'(cpu_req_index), 32'(gr_idx));
                chk("grant_data", cpu_req_data, gr_dat);
                act = 1; t0 = cyc; ptr = (w + 1) % NREQ;
                if (force_lat != -2) lat = force_lat;
                else begin
                    r   = int'($urandom_range(0, 19));
                    lat = (r == 0) ? -1 : (r == 1) ? TIMEOUT : int'($urandom_range(0, 5));
                end
                rdy_data = force_d_en ? force_d : $urandom;
                if (lat < 0) begin
                    if (m_tcnt < 255) m_tcnt++;
                    e = '{w: w, data: 32'h0, err: 1'b1, cyc: t0 + TIMEOUT + 1, tcnt: m_tcnt};
                end else
                    e = '{w: w, data: rdy_data, err: 1'b0, cyc: t0 + lat + 1, tcnt: m_tcnt};
                exp_done = e.cyc;
                sbq.push_back(e);
            end
            exp_rise = -1;
        end else if (act && cyc < exp_done) begin
            chk("hold_valid", 32'(cpu_req_valid), 1);
            chk("hold_rw", 32'(cpu_req_rw), 32'(gr_rw));
            chk("hold_index", 32'(cpu_req_index), 32'(gr_idx));
            chk("hold_data", cpu_req_data, gr_dat);
        end else if (!act) begin
            chk("idle_valid", 32'(cpu_req_valid), 0);
        end

        if (act && cyc == exp_done) begin
            act = 0; last_done = cyc; n_done++;
            if (mode == 1) new_req(cur_w);
            else rv[cur_w] = 1'b0;
        end
        if (mode == 2) begin
            if (act && $urandom_range(0, 15) == 0) rv[cur_w] = 1'b0;
            for (int i = 0; i < NREQ; i++)
                if (!rv[GW'(i)] && !(act && GW'(i) == cur_w) && $urandom_range(0, 3) == 0)
                    new_req(GW'(i));
        end

        if (act && lat >= 0 && cyc == t0 + lat) begin
            cpu_res_ready = 1'b1;
            cpu_res_data  = rdy_data;
        end else if (act) begin
            cpu_res_ready = 1'b0;
            cpu_res_data  = $urandom;
        end else begin
            cpu_res_ready = ($urandom_range(0, 2) == 0);
            cpu_res_data  = $urandom;
        end
        plan();
    endtask

    task automatic run_until(int n, int budget);
        int b = budget;
        while (n_done < n && b > 0) begin
            step();
            b--;
        end
        if (n_done < n) chk("run_budget", 32'(n_done), 32'(n));
    endtask

    task automatic do_reset();
        rst = 1'b1; rv = '0; act = 0; ptr = 0; exp_rise = -1; m_tcnt = 0; mode = 0;
        sbq.delete();
        @(negedge clk);
        chk_reset();
        rst = 1'b0;
        plan();
    endtask

    // Monitor: every completion pops the oldest expected transaction.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && req_done !== '0) begin
            if (sbq.size() == 0) chk("spurious_done", 32'(req_done), 0);
            else begin
                e = sbq.pop_front();
                chk("done_vec", 32'(req_done), 32'(1) << e.w);
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("timeout_cnt", 32'(timeout_cnt), 32'(e.tcnt));
                chk("done_cpu_valid", 32'(cpu_req_valid), 0);
                chk("done_busy", 32'(busy), 1);
            end
        end
    end

    initial begin
        int b;
        for (int i = 0; i < NREQ; i++) begin ridx[i] = '0; rdat[i] = '0; end
        repeat (2) @(negedge clk);
        chk_reset();
        rst = 1'b0;
        plan();

        // All requesters continuously asserted, cache answers in the first BUSY cycle.
        for (int i = 0; i < NREQ; i++) new_req(GW'(i));
        mode = 1; force_lat = 0;
        plan();
        run_until(5, 100);
        rv = '0; mode = 0;
        plan();

        // Requester 1 alone, then 0 and 3 together (3 goes first); 0 is a write of 0xA.
        new_req(GW'(1)); force_lat = 2; plan();
        run_until(6, 50);
        new_req(GW'(0)); rw_v[0] = 1'b1; rdat[0] = 32'h0000000A;
        new_req(GW'(3)); force_lat = 5; plan();
        run_until(8, 60);

        // Single read from requester 2.
        new_req(GW'(2)); rw_v[2] = 1'b0; ridx[2] = 14'h0040;
        force_lat = 4; force_d_en = 1; force_d = 32'h00050003; plan();
        run_until(9, 50);
        force_d_en = 0;

        // Cache never answers.
        new_req(GW'(1)); force_lat = -1; plan();
        run_until(10, TIMEOUT + 20);

        // Reset two cycles into BUSY, then arbitration restarts from requester 0.
        new_req(GW'(2)); force_lat = -1; plan();
        b = 20;
        while (!(act && cyc == t0 + 1) && b > 0) begin step(); b--; end
        if (b == 0) chk("reset_setup", 32'(act), 1);
        do_reset();
        new_req(GW'(0)); new_req(GW'(2)); force_lat = 1; plan();
        run_until(n_done + 2, 50);

        // Random traffic.
        mode = 2; force_lat = -2;
        repeat (3000) step();
        mode = 0;
        b = 2000;
        while ((rv != '0 || act) && b > 0) begin step(); b--; end
        if (b == 0) chk("drain_budget", 32'(rv), 0);
        repeat (5) step();
        chk("sb_empty", 32'(sbq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule
